gbsha_fir_top: RTL and testbench
================================

Name: gbsha_fir_top

Overview:
- Small fixed-coefficient direct-form FIR filter packaged as an 8-in/8-out tile: `io_in` carries the clock, the reset and a signed input sample; `io_out` carries the filtered signed output.
- Top-level user block of a multi-project tile; the clock and reset arrive as bits of `io_in` (no separate clock or reset pins).
- Default build is a single tap (registered gain stage); larger tap counts are selected by parameter.

Parameters:
- N_TAPS, default 1, number of FIR taps; legal range 1..8.
- BW_in, default 6, input sample width, two's complement; legal range 1..6.
- BW_out, default 8, output sample width, two's complement; fixed at 8.
- BW_coef, default 4, coefficient width, two's complement.

Ports:
- io_in  input  8  Packed tile input:
  - bit 0 = clock `clk`; all state updates on its rising edge.
  - bit 1 = reset `rst`, synchronous, active-low.
  - bits [BW_in+1:2] = x_in, signed sample.
  - bits above BW_in+1 are ignored.
- io_out  output  8  Packed tile output; bits [BW_out-1:0] = y_out, signed filtered sample.

Behaviour:
- Reset: on a rising clk edge with io_in[1]==0, all delay-line registers and the y_out register are cleared to 0. io_out reads 0x00 on the following cycle. Reset has priority over sampling, and the x_in presented during reset is discarded. A mid-stream reset flushes all history.
- Delay line: N_TAPS signed BW_in-bit registers d[0..N_TAPS-1]. Each active edge does d[0] <= x_in and d[k] <= d[k-1].
- Accumulation: acc = sum over k of COEF[k]*d[k] (with d[0] taken as the value just sampled, see latency).
  - Computed combinationally at full precision.
  - Full precision = BW_in+BW_coef+ceil(log2(N_TAPS)) bits, with sign-extension of every product.
  - No rounding and no scaling shift.
- Output register: y_out <= narrow(acc) on every active edge.
- Latency: the x_in sampled at edge n first contributes to io_out after edge n+1, with weight COEF[0]. The same sample contributes to the output after edge n+1+k with weight COEF[k].
- Narrowing to BW_out: controlled by the optional feature.
- Coefficients come from the package table, COEF[k] = COEF_TABLE[k].
  - With the default N_TAPS=1 (COEF[0]=1), io_out after edge n+1 equals the sign-extended x_in sampled at edge n.
- Unused bits of io_in are ignored. All bits of io_out are driven at all times.

Optional Feature:
- GBSHA_SATURATE_EN
  - Defined: an acc above +(2^(BW_out-1)-1) clamps to 127 (0x7F), and an acc below -2^(BW_out-1) clamps to -128 (0x80).
  - Undefined: y_out is the low BW_out bits of acc (two's-complement wrap).
  - In both builds, an in-range acc passes through unchanged.

Decomposition:
- Package gbsha_fir_pkg holds:
  - the width constants (BW_IN=6, BW_OUT=8, BW_COEF=4, MAX_TAPS=8);
  - a typedef for the signed sample, a typedef for the signed coefficient, and a typedef for the accumulator;
  - COEF_TABLE = {1,2,3,4,4,3,2,1} (signed 4-bit, index 0 first).
- One natural sub-module, gbsha_fir_core: the delay line, MAC sum, narrowing and output register, with clk, rst_n, x and y ports.
- The top only unpacks io_in and packs io_out.

Test Plan:
- Reset: hold io_in[1]=0 for 3 edges with x_in=0x1F -> io_out=0x00 throughout; the first edge after releasing reset latches the new sample.
- Default N_TAPS=1 pass-through: x_in = +31, -32, -1, 0 on consecutive edges -> io_out = 0x1F, 0xE0, 0xFF, 0x00, each one cycle later.
- N_TAPS=4 impulse: x_in = 1 for one edge, then 0 -> io_out sequence 1, 2, 3, 4, 0, 0.
- N_TAPS=4 step at x=31 (sum 310):
  - with GBSHA_SATURATE_EN -> settles at 0x7F;
  - without -> 0x36 (54).
- N_TAPS=4 step at x=-32 (sum -320):
  - with GBSHA_SATURATE_EN -> 0x80;
  - without -> 0xC0.
- Mid-stream reset: N_TAPS=4, run the step at x=5, then assert reset for one edge and return to x=0 -> io_out=0 after the reset edge and stays 0 (history flushed).

Source files
------------

// File: rtl/gbsha_fir_pkg.sv
// gbsha_fir_pkg: shared widths, sample/coefficient/accumulator types and the
// coefficient table for the gbsha FIR tile.
// Optional feature macro used by the core: GBSHA_SATURATE_EN.
package gbsha_fir_pkg;

  localparam int unsigned BW_IN    = 6;
  localparam int unsigned BW_OUT   = 8;
  localparam int unsigned BW_COEF  = 4;
  localparam int unsigned MAX_TAPS = 8;

  // Widest accumulator any legal tap count can need.
  localparam int unsigned BW_ACC = BW_IN + BW_COEF + $clog2(MAX_TAPS);

  typedef logic signed [BW_IN-1:0]   sample_t;
  typedef logic signed [BW_COEF-1:0] coef_t;
  typedef logic signed [BW_ACC-1:0]  acc_t;

  // Index 0 is the weight applied to the newest registered sample.
  localparam coef_t COEF_TABLE [MAX_TAPS] = '{
    4'sd1, 4'sd2, 4'sd3, 4'sd4, 4'sd4, 4'sd3, 4'sd2, 4'sd1
  };

endpackage

// File: rtl/gbsha_fir_core.sv
// gbsha_fir_core: delay line, full-precision MAC, narrowing and output register.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - synchronous active-low reset, clears delay line and output
//   x     - signed input sample (BW_in bits)
//   y     - registered signed filtered sample (BW_out bits)
// Macro GBSHA_SATURATE_EN: defined -> clamp to output range, undefined -> wrap.
module gbsha_fir_core
  import gbsha_fir_pkg::*;
#(
  parameter int unsigned N_TAPS  = 1,
  parameter int unsigned BW_in   = BW_IN,
  parameter int unsigned BW_out  = BW_OUT,
  parameter int unsigned BW_coef = BW_COEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [BW_in-1:0]  x,
  output logic signed [BW_out-1:0] y
);

  localparam int AccW = BW_in + BW_coef + $clog2(N_TAPS);

  logic signed [BW_in-1:0]   r_d [N_TAPS];
  logic signed [BW_out-1:0]  r_y;
  logic signed [BW_coef-1:0] w_coef [N_TAPS];
  logic signed [AccW-1:0]    w_acc;
  logic signed [AccW-1:0]    w_prod;
  logic signed [BW_out-1:0]  w_y;

  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      w_coef[k] = COEF_TABLE[k];
    end
  end

  // Operands are sign-extended to the accumulator width before multiplying so
  // every product and partial sum is exact.
  always_comb begin
    w_acc  = '0;
    w_prod = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      w_prod = AccW'(r_d[k]) * AccW'(w_coef[k]);
      w_acc  = w_acc + w_prod;
    end
  end

`ifdef GBSHA_SATURATE_EN
  localparam int MaxOut = 2 ** (BW_out - 1) - 1;
  localparam int MinOut = -(2 ** (BW_out - 1));

  always_comb begin
    w_y = BW_out'(w_acc);
    if (int'(w_acc) > MaxOut) begin
      w_y = {1'b0, {(BW_out - 1){1'b1}}};
    end else if (int'(w_acc) < MinOut) begin
      w_y = {1'b1, {(BW_out - 1){1'b0}}};
    end
  end
`else
  // Keep the low BW_out bits: two's-complement wrap.
  always_comb begin
    w_y = BW_out'(w_acc);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_d[k] <= '0;
      end
      r_y <= '0;
    end else begin
      r_d[0] <= x;
      for (int k = 1; k < N_TAPS; k++) begin
        r_d[k] <= r_d[k-1];
      end
      r_y <= w_y;
    end
  end

  assign y = r_y;

endmodule

// File: rtl/gbsha_fir_top.sv
// gbsha_fir_top: 8-in/8-out tile wrapper around gbsha_fir_core.
// Ports:
//   io_in  - [0] clock, [1] synchronous active-low reset, [BW_in+1:2] signed
//            sample; higher bits ignored
//   io_out - [BW_out-1:0] registered signed filtered sample
// Macro GBSHA_SATURATE_EN (consumed by the core) selects clamping narrowing.
module gbsha_fir_top
  import gbsha_fir_pkg::*;
#(
  parameter int unsigned N_TAPS  = 1,
  parameter int unsigned BW_in   = BW_IN,
  parameter int unsigned BW_out  = BW_OUT,
  parameter int unsigned BW_coef = BW_COEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic                     w_clk;
  logic                     w_rst_n;
  logic signed [BW_in-1:0]  w_x;
  logic signed [BW_out-1:0] w_y;

  assign w_clk   = io_in[0];
  assign w_rst_n = io_in[1];
  assign w_x     = io_in[BW_in+1:2];

  gbsha_fir_core #(
    .N_TAPS  (N_TAPS),
    .BW_in   (BW_in),
    .BW_out  (BW_out),
    .BW_coef (BW_coef)
  ) u_core (
    .clk   (w_clk),
    .rst_n (w_rst_n),
    .x     (w_x),
    .y     (w_y)
  );

  assign io_out = w_y;

endmodule

// File: tb/tb_gbsha_fir_top.sv
module tb_gbsha_fir_top;

  logic       r_clk;
  logic       r_rst_n;
  logic [5:0] r_x;
  logic [7:0] io_in;
  logic [7:0] io_out1;
  logic [7:0] io_out4;

  int checks   = 0;
  int failures = 0;

  // Reference history: index 0 is the newest latched sample.
  int h1;
  int h4 [4];
  logic [7:0] q1 [$];
  logic [7:0] q4 [$];

  assign io_in = {r_x, r_rst_n, r_clk};

  gbsha_fir_top u_dut1 (
    .io_in  (io_in),
    .io_out (io_out1)
  );

  gbsha_fir_top #(.N_TAPS(4)) u_dut4 (
    .io_in  (io_in),
    .io_out (io_out4)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  function automatic logic [7:0] narrow(input int a);
    logic [31:0] t;
`ifdef GBSHA_SATURATE_EN
    if (a > 127) return 8'h7F;
    if (a < -128) return 8'h80;
`endif
    t = a;
    return t[7:0];
  endfunction

  // Drive one edge; push what each DUT must show right after that edge.
  task automatic cycle(input logic rn, input int x);
    logic [31:0] xv;
    xv      = x;
    r_rst_n = rn;
    r_x     = xv[5:0];
    if (!rn) begin
      q1.push_back(8'h00);
      q4.push_back(8'h00);
      h1 = 0;
      h4 = '{default: 0};
    end else begin
      q1.push_back(narrow(h1));
      q4.push_back(narrow(1 * h4[0] + 2 * h4[1] + 3 * h4[2] + 4 * h4[3]));
      h4[3] = h4[2];
      h4[2] = h4[1];
      h4[1] = h4[0];
      h4[0] = x;
      h1    = x;
    end
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] e1, e4;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 31);
      e1 = q1.pop_front();
      e4 = q4.pop_front();
      checks++;
      if (io_out1 !== 8'h00) begin
        failures++;
        $display("FAIL reset_tap1: dut=%h exp=00", io_out1);
      end
      checks++;
      if (io_out4 !== e4) begin
        failures++;
        $display("FAIL reset_tap4: dut=%h exp=%h", io_out4, e4);
      end
    end
    // First edge after release latches 5; it appears one edge later.
    cycle(1'b1, 5);
    e1 = q1.pop_front();
    e4 = q4.pop_front();
    checks++;
    if (io_out1 !== e1) begin
      failures++;
      $display("FAIL release_first: dut=%h exp=%h", io_out1, e1);
    end
    cycle(1'b1, 0);
    e1 = q1.pop_front();
    e4 = q4.pop_front();
    checks++;
    if (io_out1 !== 8'h05) begin
      failures++;
      $display("FAIL release_latch: dut=%h exp=05", io_out1);
    end
    checks++;
    if (io_out4 !== e4) begin
      failures++;
      $display("FAIL release_tap4: dut=%h exp=%h", io_out4, e4);
    end
  endtask

  task automatic test_passthrough;
    int         seq [4] = '{31, -32, -1, 0};
    logic [7:0] exp [4] = '{8'h1F, 8'hE0, 8'hFF, 8'h00};
    logic [7:0] e1, e4;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, (i < 4) ? seq[i] : 0);
      e1 = q1.pop_front();
      e4 = q4.pop_front();
      checks++;
      if (io_out1 !== e1) begin
        failures++;
        $display("FAIL pass_sb[%0d]: dut=%h exp=%h", i, io_out1, e1);
      end
      checks++;
      if (io_out4 !== e4) begin
        failures++;
        $display("FAIL pass_tap4[%0d]: dut=%h exp=%h", i, io_out4, e4);
      end
      if (i >= 1) begin
        checks++;
        if (io_out1 !== exp[i-1]) begin
          failures++;
          $display("FAIL pass_const[%0d]: dut=%h exp=%h", i, io_out1, exp[i-1]);
        end
      end
    end
  endtask

  task automatic test_flush;
    logic [7:0] e1, e4;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 0);
      e1 = q1.pop_front();
      e4 = q4.pop_front();
      checks++;
      if (io_out4 !== e4) begin
        failures++;
        $display("FAIL flush[%0d]: dut=%h exp=%h", i, io_out4, e4);
      end
    end
  endtask

  task automatic test_impulse;
    logic [7:0] exp [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
    logic [7:0] e1, e4;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, (i == 0) ? 1 : 0);
      e1 = q1.pop_front();
      e4 = q4.pop_front();
      checks++;
      if (io_out4 !== e4) begin
        failures++;
        $display("FAIL impulse_sb[%0d]: dut=%h exp=%h", i, io_out4, e4);
      end
      checks++;
      if (io_out4 !== exp[i]) begin
        failures++;
        $display("FAIL impulse_const[%0d]: dut=%h exp=%h", i, io_out4, exp[i]);
      end
    end
  endtask

  task automatic test_step(input int x, input logic [7:0] settle);
    logic [7:0] e1, e4;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, x);
      e1 = q1.pop_front();
      e4 = q4.pop_front();
      checks++;
      if (io_out4 !== e4) begin
        failures++;
        $display("FAIL step_sb[x=%0d,%0d]: dut=%h exp=%h", x, i, io_out4, e4);
      end
      checks++;
      if (io_out1 !== e1) begin
        failures++;
        $display("FAIL step_tap1[x=%0d,%0d]: dut=%h exp=%h", x, i, io_out1, e1);
      end
    end
    checks++;
    if (io_out4 !== settle) begin
      failures++;
      $display("FAIL step_settle[x=%0d]: dut=%h exp=%h", x, io_out4, settle);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] e1, e4;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 5);
      e1 = q1.pop_front();
      e4 = q4.pop_front();
    end
    checks++;
    if (io_out4 !== 8'd50) begin
      failures++;
      $display("FAIL midrst_pre: dut=%h exp=%h", io_out4, 8'd50);
    end
    cycle(1'b0, 0);
    e1 = q1.pop_front();
    e4 = q4.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (io_out4 !== 8'h00 || io_out4 !== e4) begin
        failures++;
        $display("FAIL midrst_flush[%0d]: dut=%h exp=%h", i, io_out4, e4);
      end
      checks++;
      if (io_out1 !== 8'h00) begin
        failures++;
        $display("FAIL midrst_tap1[%0d]: dut=%h exp=00", i, io_out1);
      end
      cycle(1'b1, 0);
      e1 = q1.pop_front();
      e4 = q4.pop_front();
    end
  endtask

  initial begin
    r_rst_n = 1'b0;
    r_x     = '0;
    h1      = 0;
    h4      = '{default: 0};
    test_reset();
    test_passthrough();
    test_flush();
    test_impulse();
`ifdef GBSHA_SATURATE_EN
    test_step(31, 8'h7F);
    test_flush();
    test_step(-32, 8'h80);
`else
    test_step(31, 8'h36);
    test_flush();
    test_step(-32, 8'hC0);
`endif
    test_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
